// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared definitions for the PS/2 host command scheduler: protocol
//            byte constants, the scheduler state encoding and a small helper
//            that turns a requester index into a one-hot strobe vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Device response bytes
    localparam logic [7:0] ACK          = 8'hFA;
    localparam logic [7:0] RESEND       = 8'hFE;

    // Commonly issued host commands / device status
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] SELF_TEST    = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_SEND_CMD       = 3'd1,
        S_WAIT_CMD_ACK   = 3'd2,
        S_SEND_PARAM     = 3'd3,
        S_WAIT_PARAM_ACK = 3'd4
    } sched_state_t;

    // Requester index -> per-requester strobe vector
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_scheduler_if
// Purpose  : Bundles the requester handshake, transceiver byte interface and
//            scan-code forwarding path of the PS/2 command scheduler.
// Modports : slave  - the scheduler itself
//            master - the surrounding logic (requesters, transceiver, decoder)
// Signals  : req_valid/req_cmd/req_has_param/req_param  request side (2 lanes)
//            req_grant/req_done/req_error               per-requester pulses
//            dev_write/dev_tx_data/dev_busy             transmit path
//            dev_read/dev_rx_data                       receive path
//            key_valid/key_data                         forwarded bytes
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_cmd_scheduler_if;

    logic [1:0]  req_valid;
    logic [15:0] req_cmd;
    logic [1:0]  req_has_param;
    logic [15:0] req_param;
    logic [1:0]  req_grant;
    logic [1:0]  req_done;
    logic [1:0]  req_error;

    logic        dev_write;
    logic [7:0]  dev_tx_data;
    logic        dev_busy;
    logic        dev_read;
    logic [7:0]  dev_rx_data;

    logic        key_valid;
    logic [7:0]  key_data;

    modport slave (
        input  req_valid, req_cmd, req_has_param, req_param,
        output req_grant, req_done, req_error,
        output dev_write, dev_tx_data,
        input  dev_busy, dev_read, dev_rx_data,
        output key_valid, key_data
    );

    modport master (
        output req_valid, req_cmd, req_has_param, req_param,
        input  req_grant, req_done, req_error,
        input  dev_write, dev_tx_data,
        output dev_busy, dev_read, dev_rx_data,
        input  key_valid, key_data
    );

endinterface
`default_nettype wire

// File: rtl/ps2_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_timeout_timer
// Purpose  : Loadable down-counter used to time out a device response.
//            load_i reloads TIMEOUT_CYCLES; while en_i is high the count
//            decrements once per cycle and stops at zero (never wraps).
//            expired_o is high while enabled with the count at zero.
// Ports    : clk       in  1  system clock
//            reset     in  1  asynchronous, active-high reset
//            load_i    in  1  reload the counter with TIMEOUT_CYCLES
//            en_i      in  1  count down / qualify expiry
//            expired_o out 1  timeout reached
// Revision : 1.0 - initial release
// ============================================================================
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 502500
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = en_i && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_scheduler
// Purpose  : Host-side PS/2 command sequencer and two-way round-robin arbiter.
//            Grants one requester at a time, sends its command byte and an
//            optional parameter byte to the transceiver, waits for ACK,
//            retransmits on RESEND or timeout (up to MAX_RETRIES times) and
//            reports done/error. Bytes that are not part of an exchange are
//            forwarded to the scan-code decoder one cycle after receipt.
// Ports    : clk    in  1  system clock
//            reset  in  1  asynchronous, active-high reset
//            bus    ps2_cmd_scheduler_if.slave (requesters, transceiver,
//                   key forwarding)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_cmd_scheduler #(
    parameter int TIMEOUT_CYCLES = 502500,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_cmd_scheduler_if.slave    bus
);

    import ps2_pkg::*;

    localparam int               RETRY_W   = $clog2(MAX_RETRIES + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sched_state_t       state_q, state_d;
    logic               prio_q, prio_d;        // requester that wins a tie
    logic               owner_q, owner_d;      // requester being served
    logic [7:0]         cmd_q, cmd_d;
    logic               has_param_q, has_param_d;
    logic [7:0]         param_q, param_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [7:0]         last_tx_q, last_tx_d;  // holds dev_tx_data between strobes
    logic [1:0]         done_q, done_d;
    logic [1:0]         error_q, error_d;
    logic               key_valid_q, key_valid_d;
    logic [7:0]         key_data_q, key_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_pick;
    logic [1:0] w_grant;
    logic       w_write;
    logic [7:0] w_tx_byte;
    logic       w_timer_load;
    logic       w_timer_en;
    logic       w_timer_expired;
    logic       w_in_wait;
    logic       w_rx_ack;
    logic       w_rx_resend;

    assign w_in_wait   = (state_q == S_WAIT_CMD_ACK) || (state_q == S_WAIT_PARAM_ACK);
    assign w_rx_ack    = bus.dev_read && (bus.dev_rx_data == ACK);
    assign w_rx_resend = bus.dev_read && (bus.dev_rx_data == RESEND);

    // A lone request wins outright; a tie goes to the requester that was
    // not served last.
    always_comb begin
        w_pick = prio_q;
        if (bus.req_valid == 2'b01) begin
            w_pick = 1'b0;
        end else if (bus.req_valid == 2'b10) begin
            w_pick = 1'b1;
        end
    end

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (w_timer_load),
        .en_i      (w_timer_en),
        .expired_o (w_timer_expired)
    );

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        has_param_d  = has_param_q;
        param_d      = param_q;
        retry_d      = retry_q;
        last_tx_d    = last_tx_q;
        done_d       = '0;
        error_d      = '0;
        w_grant      = '0;
        w_write      = 1'b0;
        w_tx_byte    = last_tx_q;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant is combinational so the grant pulse coincides with
                // the latch; gating with reset keeps every output at 0
                // while reset is held.
                if ((bus.req_valid != 2'b00) && !reset) begin
                    owner_d     = w_pick;
                    prio_d      = ~w_pick;
                    cmd_d       = w_pick ? bus.req_cmd[15:8]   : bus.req_cmd[7:0];
                    param_d     = w_pick ? bus.req_param[15:8] : bus.req_param[7:0];
                    has_param_d = w_pick ? bus.req_has_param[1] : bus.req_has_param[0];
                    retry_d     = '0;
                    w_grant     = onehot2(w_pick);
                    state_d     = S_SEND_CMD;
                end
            end

            S_SEND_CMD: begin
                if (!bus.dev_busy) begin
                    w_write      = 1'b1;
                    w_tx_byte    = cmd_q;
                    last_tx_d    = cmd_q;
                    w_timer_load = 1'b1;
                    state_d      = S_WAIT_CMD_ACK;
                end
            end

            S_SEND_PARAM: begin
                if (!bus.dev_busy) begin
                    w_write      = 1'b1;
                    w_tx_byte    = param_q;
                    last_tx_d    = param_q;
                    w_timer_load = 1'b1;
                    state_d      = S_WAIT_PARAM_ACK;
                end
            end

            S_WAIT_CMD_ACK, S_WAIT_PARAM_ACK: begin
                w_timer_en = 1'b1;
                // ACK is tested first so it beats a timeout in the same cycle.
                if (w_rx_ack) begin
                    retry_d = '0;
                    if ((state_q == S_WAIT_CMD_ACK) && has_param_q) begin
                        state_d = S_SEND_PARAM;
                    end else begin
                        done_d  = onehot2(owner_q);
                        state_d = S_IDLE;
                    end
                end else if (w_rx_resend || w_timer_expired) begin
                    if (retry_q == RETRY_MAX) begin
                        error_d = onehot2(owner_q);
                        state_d = S_IDLE;
                    end else begin
                        retry_d = retry_q + RETRY_ONE;
                        state_d = (state_q == S_WAIT_CMD_ACK) ? S_SEND_CMD : S_SEND_PARAM;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Only ACK/RESEND received while an answer is awaited are consumed;
    // everything else goes to the decoder.
    always_comb begin
        key_valid_d = 1'b0;
        key_data_d  = key_data_q;
        if (bus.dev_read && !(w_in_wait && (w_rx_ack || w_rx_resend))) begin
            key_valid_d = 1'b1;
            key_data_d  = bus.dev_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            cmd_q       <= '0;
            has_param_q <= 1'b0;
            param_q     <= '0;
            retry_q     <= '0;
            last_tx_q   <= '0;
            done_q      <= '0;
            error_q     <= '0;
            key_valid_q <= 1'b0;
            key_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            cmd_q       <= cmd_d;
            has_param_q <= has_param_d;
            param_q     <= param_d;
            retry_q     <= retry_d;
            last_tx_q   <= last_tx_d;
            done_q      <= done_d;
            error_q     <= error_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_grant   = w_grant;
    assign bus.req_done    = done_q;
    assign bus.req_error   = error_q;
    assign bus.dev_write   = w_write;
    assign bus.dev_tx_data = w_write ? w_tx_byte : last_tx_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_data    = key_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_cmd_scheduler
// Purpose  : Self-checking bench for ps2_cmd_scheduler. Expected grants,
//            done/error pulses, transmitted bytes and forwarded bytes are
//            queued when stimulus is applied and compared as the DUT
//            produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_cmd_scheduler;

    localparam int TIMEOUT_CYCLES = 100;
    localparam int MAX_RETRIES    = 3;

    // Event queue encoding: upper nibble = kind, low bits = requester vector
    localparam logic [7:0] EV_GRANT = 8'h10;
    localparam logic [7:0] EV_DONE  = 8'h20;
    localparam logic [7:0] EV_ERROR = 8'h40;

    logic clk;
    logic reset;

    ps2_cmd_scheduler_if bus ();

    ps2_cmd_scheduler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int last_wr_cyc = 0;
    int last_rd_cyc = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_key_q[$];
    logic [7:0] exp_evt_q[$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {8'h00, bus.req_grant, bus.req_done, bus.req_error, bus.dev_write,
                bus.key_valid, bus.key_data, bus.dev_tx_data};
    endfunction

    // ------------------------------------------------------------------
    // Output monitor / scoreboard (samples on the falling edge)
    // ------------------------------------------------------------------
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.key_valid) begin
                check_value("key_lat", cyc - last_rd_cyc, 1);
                check_value("key_avail", exp_key_q.size() != 0, 1);
                if (exp_key_q.size() != 0) begin
                    mon_exp = exp_key_q.pop_front();
                    check_value("key_data", bus.key_data, mon_exp);
                end
            end
            if (bus.dev_read) last_rd_cyc = cyc;
            if (bus.dev_write) begin
                check_value("wr_busy", bus.dev_busy, 0);
                n_writes++;
                last_wr_cyc = cyc;
                check_value("tx_avail", exp_tx_q.size() != 0, 1);
                if (exp_tx_q.size() != 0) begin
                    mon_exp = exp_tx_q.pop_front();
                    check_value("tx_data", bus.dev_tx_data, mon_exp);
                end
            end
            // done/error are compared before a same-cycle grant so the
            // previous command must finish no later than the next grant.
            if ((bus.req_done | bus.req_error) != 2'b00) begin
                check_value("evt_avail", exp_evt_q.size() != 0, 1);
                if (exp_evt_q.size() != 0) begin
                    mon_exp = exp_evt_q.pop_front();
                    check_value("done_err", (bus.req_done != 2'b00) ? (EV_DONE | bus.req_done)
                                                                   : (EV_ERROR | bus.req_error), mon_exp);
                end
            end
            if (bus.req_grant != 2'b00) begin
                check_value("grant_avail", exp_evt_q.size() != 0, 1);
                if (exp_evt_q.size() != 0) begin
                    mon_exp = exp_evt_q.pop_front();
                    check_value("grant", EV_GRANT | bus.req_grant, mon_exp);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_evt(input logic [7:0] kind, input logic [1:0] who);
        exp_evt_q.push_back(kind | {6'b0, who});
    endtask

    task automatic issue(input int idx, input logic [7:0] cmd, input logic hp, input logic [7:0] prm);
        bus.req_cmd[idx*8 +: 8]   = cmd;
        bus.req_param[idx*8 +: 8] = prm;
        bus.req_has_param[idx]    = hp;
        bus.req_valid[idx]        = 1'b1;
        @(posedge clk); #1;
        bus.req_valid[idx]        = 1'b0;
    endtask

    task automatic wait_write();
        int start;
        int k;
        start = n_writes;
        k = 0;
        while ((n_writes == start) && (k < 600)) begin
            @(posedge clk);
            k++;
        end
        check_value("wr_seen", n_writes != start, 1);
    endtask

    // Transceiver model: busy after a write, answer while still busy,
    // then stay busy a little longer so a retransmit has to wait.
    task automatic respond(input logic [7:0] b, input logic drop_valid);
        wait_write();
        @(posedge clk); #1 bus.dev_busy = 1'b1;
        @(posedge clk); #1 bus.dev_read = 1'b1; bus.dev_rx_data = b;
        @(posedge clk); #1 bus.dev_read = 1'b0;
        if (drop_valid) bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 bus.dev_busy = 1'b0;
    endtask

    task automatic pulse_read(input logic [7:0] b);
        bus.dev_read = 1'b1;
        bus.dev_rx_data = b;
        @(posedge clk); #1 bus.dev_read = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (((exp_tx_q.size() + exp_evt_q.size() + exp_key_q.size()) != 0) && (k < 1000)) begin
            @(posedge clk);
            k++;
        end
        check_value("drain", exp_tx_q.size() + exp_evt_q.size() + exp_key_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int prev;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.req_has_param = '0;
        bus.req_param = '0;
        bus.dev_busy = 1'b0;
        bus.dev_read = 1'b0;
        bus.dev_rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_outs", outs(), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Arbitration: both requesters held high -> 0, 1, 0
        push_evt(EV_GRANT, 2'b01); exp_tx_q.push_back(8'hF4); push_evt(EV_DONE, 2'b01);
        push_evt(EV_GRANT, 2'b10); exp_tx_q.push_back(8'hED); exp_tx_q.push_back(8'h00);
        push_evt(EV_DONE, 2'b10);
        push_evt(EV_GRANT, 2'b01); exp_tx_q.push_back(8'hF4); push_evt(EV_DONE, 2'b01);
        bus.req_cmd = {8'hED, 8'hF4};
        bus.req_has_param = 2'b10;
        bus.req_param = 16'h0000;
        bus.req_valid = 2'b11;
        respond(8'hFA, 1'b0);
        respond(8'hFA, 1'b0);
        respond(8'hFA, 1'b0);
        respond(8'hFA, 1'b1);
        wait_idle();

        // LED update with the transceiver busy at grant time
        push_evt(EV_GRANT, 2'b01); exp_tx_q.push_back(8'hED); exp_tx_q.push_back(8'h04);
        push_evt(EV_DONE, 2'b01);
        bus.dev_busy = 1'b1;
        issue(0, 8'hED, 1'b1, 8'h04);
        repeat (4) @(posedge clk);
        #1 bus.dev_busy = 1'b0;
        respond(8'hFA, 1'b0);
        respond(8'hFA, 1'b0);
        wait_idle();

        // Resend recovered: FE, FE, FA
        push_evt(EV_GRANT, 2'b01);
        repeat (3) exp_tx_q.push_back(8'hF4);
        push_evt(EV_DONE, 2'b01);
        issue(0, 8'hF4, 1'b0, 8'h00);
        respond(8'hFE, 1'b0);
        respond(8'hFE, 1'b0);
        respond(8'hFA, 1'b0);
        wait_idle();

        // Resend exhausted: FE x4 -> error
        push_evt(EV_GRANT, 2'b10);
        repeat (4) exp_tx_q.push_back(8'hF4);
        push_evt(EV_ERROR, 2'b10);
        issue(1, 8'hF4, 1'b0, 8'h00);
        repeat (4) respond(8'hFE, 1'b0);
        wait_idle();

        // Timeout: no answer at all
        push_evt(EV_GRANT, 2'b01);
        repeat (4) exp_tx_q.push_back(8'hF4);
        push_evt(EV_ERROR, 2'b01);
        issue(0, 8'hF4, 1'b0, 8'h00);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_write();
            if (i > 0) begin
                check_value("to_gap", ((last_wr_cyc - prev) >= TIMEOUT_CYCLES) &&
                                      ((last_wr_cyc - prev) <= TIMEOUT_CYCLES + 4), 1);
            end
            prev = last_wr_cyc;
        end
        wait_idle();

        // Scan code interleaved in WAIT_CMD_ACK
        push_evt(EV_GRANT, 2'b01); exp_tx_q.push_back(8'hF4);
        exp_key_q.push_back(8'h1C); push_evt(EV_DONE, 2'b01);
        issue(0, 8'hF4, 1'b0, 8'h00);
        wait_write();
        #1 pulse_read(8'h1C);
        repeat (2) @(posedge clk);
        #1 pulse_read(8'hFA);
        wait_idle();

        // Reset during WAIT_PARAM_ACK, then a stray FA is forwarded
        push_evt(EV_GRANT, 2'b10); exp_tx_q.push_back(8'hED); exp_tx_q.push_back(8'h04);
        issue(1, 8'hED, 1'b1, 8'h04);
        respond(8'hFA, 1'b0);
        wait_write();
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_value("rst_mid_outs", outs(), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        exp_key_q.push_back(8'hFA);
        pulse_read(8'hFA);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
Host-side command sequencer and arbiter for the PS/2 port. It sits between up to two command requesters and the PS/2 byte transceiver (ps2_device). One requester is the LED/caps-lock logic; the other is the self-test/enable logic.
- Grants requesters round-robin and drives single- or two-byte commands to the transceiver.
- Consumes ACK (8'hFA) and RESEND (8'hFE) responses, retries on RESEND or timeout, and reports done or error per requester.
- Forwards every other received byte to the scan-code decoder.

Parameters:
TIMEOUT_CYCLES, 502500, cycles to wait for a response byte (20 ms at 25.125 MHz).
MAX_RETRIES, 3, resends allowed per byte before the command is abandoned.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester command request; bit i = requester i
req_cmd  in  16  command byte; [8i+7:8i] = requester i
req_has_param  in  2  1 = command is followed by a parameter byte
req_param  in  16  parameter byte per requester
req_grant  out  2  one-cycle pulse when the request is latched
req_done  out  2  one-cycle pulse when all bytes are ACKed
req_error  out  2  one-cycle pulse when retries are exhausted
dev_write  out  1  one-cycle transmit strobe to the transceiver
dev_tx_data  out  8  byte to transmit; stable from the strobe until the next strobe
dev_busy  in  1  transceiver not idle
dev_read  in  1  one-cycle received-byte strobe
dev_rx_data  in  8  received byte
key_valid  out  1  one-cycle strobe: forwarded byte
key_data  out  8  forwarded byte

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on port `reset`.
- Values under reset:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer points at requester 0.
  - Timer and retry counter are 0.
- States: IDLE, SEND_CMD, WAIT_CMD_ACK, SEND_PARAM, WAIT_PARAM_ACK.
- IDLE:
  - When any req_valid bit is set, grant one requester.
  - If both bits are set, grant the requester not granted most recently. After reset, requester 0 wins a tie.
  - Latch cmd, has_param and param; pulse req_grant[i]; go to SEND_CMD.
  - The requester may drop req_valid after the grant. The latched copy is used.
- SEND_CMD / SEND_PARAM:
  - Wait while dev_busy=1.
  - On the first cycle with dev_busy=0, assert dev_write=1 for exactly one cycle with dev_tx_data = the byte, load the timer with TIMEOUT_CYCLES, and go to the matching WAIT state.
  - dev_write is never asserted while dev_busy=1.
- WAIT_x_ACK, on dev_read=1:
  - rx=FA, in WAIT_CMD_ACK: clear the retry counter. If has_param, go to SEND_PARAM. Otherwise pulse req_done[i] and go to IDLE.
  - rx=FA, in WAIT_PARAM_ACK: pulse req_done[i]; go to IDLE.
  - rx=FE: the retry counter increments. If it was already MAX_RETRIES, pulse req_error[i] and go to IDLE. Otherwise return to the same SEND state and retransmit the same byte.
  - Any other byte: forward it on key_valid/key_data in the next cycle. State and timer are unaffected.
- WAIT_x_ACK, timer: decrements every cycle. On reaching 0 it behaves exactly as an RE rx=FE.
- Simultaneous events:
  - dev_read with FA in the same cycle the timer reaches 0: the ACK wins.
  - A new req_valid in any non-IDLE state is held off; it is not latched until the next IDLE.
- Forwarding: in IDLE and SEND states every received byte is forwarded, including a stray FA/FE. Forwarding latency is 1 cycle.
- Reset mid-command:
  - Immediate return to IDLE with dev_write=0.
  - No req_done or req_error pulse; the pending command is dropped.
- Widths:
  - Timer: $clog2(TIMEOUT_CYCLES+1) bits.
  - Retry counter: $clog2(MAX_RETRIES+1) bits, saturating.
  - No wrap-around is permitted.
- Minimum exchange: a granted command with no parameter takes at least 3 cycles from grant to req_done.

Decomposition:
- Shared package ps2_pkg holds:
  - the byte constants ACK=8'hFA, RESEND=8'hFE, CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, SELF_TEST=8'hAA;
  - the scheduler state enum.
- Sub-module ps2_timeout_timer provides a loadable down-counter with a `load` input and an `expired` output, parameterised by TIMEOUT_CYCLES.
- Arbitration and the FSM stay in the top module.

Test Plan:
- LED update: req_valid=2'b01, cmd=ED, has_param=1, param=04; bench returns FA, FA -> dev_tx_data sequence ED then 04, one req_done[0] pulse, no key_valid.
- Arbitration: both requesters valid together after reset (req0 cmd F4, req1 cmd ED+00), both held high -> grants in order 0, 1, 0, …; each command completes before the next grant.
- Resend: F4 answered FE, FE, FA -> F4 transmitted 3 times, then req_done; answered FE ×4 -> 4 transmissions (1 initial + MAX_RETRIES=3 resends), then req_error pulse, state IDLE.
- Timeout: TIMEOUT_CYCLES=100 with no response -> retransmit every ~100 cycles; req_error after the 4th transmission; dev_write never asserted while dev_busy=1.
- Interleaved scan code: during WAIT_CMD_ACK deliver 1C, then FA -> key_valid with key_data=1C one cycle later; command still completes with req_done.
- Reset mid-command: assert reset during WAIT_PARAM_ACK -> all outputs 0 immediately; a later FA on dev_rx_data is forwarded as key_data=FA.
